// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the PC / instruction fetch unit.
package pc_fetch_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request issued, ack may arrive this cycle
      WAIT  = 2'd1,   // request outstanding, address held
      VALID = 2'd2,   // instruction held for decode until retirement
      TRAP  = 2'd3    // misaligned next PC seen; parked until reset
   } fetch_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/pc_register.sv
// pc_register: NBITS register with async active-low reset to RESET_PC and a
// load enable. Shared by the fetch PC and any later pipeline PC copies.
module pc_register #(
   parameter int               NBITS    = 32,
   parameter logic [NBITS-1:0] RESET_PC = NBITS'(32'h0040_0000)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [NBITS-1:0] d,
   output logic [NBITS-1:0] q
);

   // Load a new PC only when enabled; reset returns to the text segment base
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= RESET_PC;
      else if (load_en)
         q <= d;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus req/ack instruction fetch for the
// single-cycle core. Holds each fetched word until the core retires it.
// Optional build macro RETIRE_COUNT_EN adds retire_count_o, a free-running
// count of accepted advances (including the one that traps).
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int               NBITS    = 32,
   parameter logic [NBITS-1:0] RESET_PC = NBITS'(32'h0040_0000)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] next_pc_i,
   input  logic             advance_i,
   input  logic             fetch_ack_i,
   input  logic [NBITS-1:0] fetch_data_i,
   output logic             fetch_req_o,
   output logic [NBITS-1:0] fetch_addr_o,
   output logic [NBITS-1:0] pc_o,
   output logic [NBITS-1:0] pc_plus_4_o,
   output logic [NBITS-1:0] instr_o,
   output logic             instr_valid_o,
   output logic             misaligned_o
`ifdef RETIRE_COUNT_EN
   ,
   output logic [NBITS-1:0] retire_count_o
`endif
);

   fetch_state_t     state_q, state_d;
   logic [NBITS-1:0] pc_q;
   logic [NBITS-1:0] instr_q;
   logic             misaligned_q;
   logic             aligned;
   logic             capture;    // latch fetch_data_i this cycle
   logic             accept;     // core retires the held instruction
   logic             pc_load;

   assign aligned = (next_pc_i[1:0] == 2'b00);
   assign pc_load = accept & aligned;

   pc_register #(
      .NBITS    (NBITS),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .load_en (pc_load),
      .d       (next_pc_i),
      .q       (pc_q)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= FETCH;
      else
         state_q <= state_d;
   end

   // Next-state logic; advance and ack are only looked at in the states that use them
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = fetch_ack_i ? VALID : WAIT;
         WAIT:    if (fetch_ack_i) state_d = VALID;
         VALID:   if (advance_i) state_d = aligned ? FETCH : TRAP;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   // Output / control decode from the current state
   always_comb begin
      fetch_req_o   = 1'b0;
      instr_valid_o = 1'b0;
      capture       = 1'b0;
      accept        = 1'b0;
      case (state_q)
         FETCH, WAIT: begin
            // Reset sits in FETCH; gate the request so nothing is issued while held
            fetch_req_o = reset;
            capture     = fetch_ack_i;
         end
         VALID: begin
            instr_valid_o = 1'b1;
            accept        = advance_i;
         end
         default: ;
      endcase
   end

   // Instruction holding register; only an ack to an outstanding request writes it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         instr_q <= NBITS'(NOP_INSTR);
      else if (capture)
         instr_q <= fetch_data_i;
   end

   // Sticky misalignment flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         misaligned_q <= 1'b0;
      else if (accept && !aligned)
         misaligned_q <= 1'b1;
   end

`ifdef RETIRE_COUNT_EN
   logic [NBITS-1:0] retire_cnt_q;

   // Count every accepted advance, wrapping naturally at 2^NBITS
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         retire_cnt_q <= '0;
      else if (accept)
         retire_cnt_q <= retire_cnt_q + NBITS'(1);
   end

   assign retire_count_o = retire_cnt_q;
`endif

   assign pc_o         = pc_q;
   assign fetch_addr_o = pc_q;
   assign pc_plus_4_o  = pc_q + NBITS'(PC_INCREMENT);
   assign instr_o      = instr_q;
   assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed test of pc_fetch_unit with hand-computed expectations.
// Inputs are driven just after the falling edge and outputs sampled there too.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] next_pc;
   logic        advance;
   logic        ack;
   logic [31:0] data;
   logic        req;
   logic [31:0] addr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] instr;
   logic        valid;
   logic        mis;
`ifdef RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int n_chk = 0;
   int n_err = 0;

   pc_fetch_unit #(
      .NBITS    (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .next_pc_i     (next_pc),
      .advance_i     (advance),
      .fetch_ack_i   (ack),
      .fetch_data_i  (data),
      .fetch_req_o   (req),
      .fetch_addr_o  (addr),
      .pc_o          (pc),
      .pc_plus_4_o   (pc4),
      .instr_o       (instr),
      .instr_valid_o (valid),
      .misaligned_o  (mis)
`ifdef RETIRE_COUNT_EN
      ,
      .retire_count_o (retire_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; advance = 1'b0; ack = 1'b0; data = '0; next_pc = '0;
      tick();
      chk("rst_pc",    pc,    RST_PC);
      chk("rst_pc4",   pc4,   32'h0040_0004);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_req",   {31'b0, req},   32'd0);
      chk("rst_mis",   {31'b0, mis},   32'd0);
`ifdef RETIRE_COUNT_EN
      chk("rst_retire", retire_count, 32'd0);
`endif

      // ack while in reset is ignored
      ack = 1'b1; data = 32'h1234_5678;
      tick();
      chk("rst_ack_instr", instr, NOP);
      chk("rst_ack_req",   {31'b0, req}, 32'd0);

      // release with same-cycle ack
      reset = 1'b1; ack = 1'b1; data = 32'h0050_0093;
      #1;
      chk("f0_req",  {31'b0, req}, 32'd1);
      chk("f0_addr", addr, RST_PC);
      chk("f0_valid", {31'b0, valid}, 32'd0);
      tick();
      ack = 1'b0;
      chk("f0_vld",   {31'b0, valid}, 32'd1);
      chk("f0_instr", instr, 32'h0050_0093);
      chk("f0_req_lo", {31'b0, req}, 32'd0);
      chk("f0_pc",    pc,  RST_PC);
      chk("f0_pc4",   pc4, 32'h0040_0004);

      // stray ack in VALID must not touch instr_o
      ack = 1'b1; data = 32'hDEAD_BEEF;
      tick();
      ack = 1'b0;
      chk("stray_instr", instr, 32'h0050_0093);
      chk("stray_valid", {31'b0, valid}, 32'd1);

      // aligned advance
      advance = 1'b1; next_pc = 32'h0040_0020;
      tick();
      advance = 1'b0;
      chk("adv_pc",    pc, 32'h0040_0020);
      chk("adv_valid", {31'b0, valid}, 32'd0);
      chk("adv_req",   {31'b0, req}, 32'd1);
      chk("adv_addr",  addr, 32'h0040_0020);

      // ack delayed 3 cycles; advance attempts while waiting are ignored
      for (int i = 0; i < 3; i++) begin
         chk("dly_req",  {31'b0, req}, 32'd1);
         chk("dly_addr", addr, 32'h0040_0020);
         advance = 1'b1; next_pc = 32'h0040_0100;
         tick();
      end
      advance = 1'b0;
      chk("dly_req4",  {31'b0, req}, 32'd1);
      chk("dly_pc",    pc, 32'h0040_0020);
      chk("dly_valid", {31'b0, valid}, 32'd0);
      ack = 1'b1; data = 32'h00A0_0113;
      tick();
      ack = 1'b0;
      chk("dly_vld",   {31'b0, valid}, 32'd1);
      chk("dly_instr", instr, 32'h00A0_0113);
      chk("dly_req_lo", {31'b0, req}, 32'd0);

      // self-loop refetches the same address
      advance = 1'b1; next_pc = 32'h0040_0020;
      tick();
      advance = 1'b0;
      chk("self_pc",  pc, 32'h0040_0020);
      chk("self_req", {31'b0, req}, 32'd1);
      chk("self_valid", {31'b0, valid}, 32'd0);
      ack = 1'b1; data = 32'h0000_0113;
      tick();
      ack = 1'b0;
      chk("self_instr", instr, 32'h0000_0113);

      // top of address space: pc+4 wraps to zero
      advance = 1'b1; next_pc = 32'hFFFF_FFFC;
      tick();
      advance = 1'b0;
      chk("wrap_pc",  pc,  32'hFFFF_FFFC);
      chk("wrap_pc4", pc4, 32'h0000_0000);
      ack = 1'b1; data = 32'h0010_0093;
      tick();
      ack = 1'b0;
      chk("wrap_instr", instr, 32'h0010_0093);

      // two more retirements: five in total
      advance = 1'b1; next_pc = 32'h0000_0000;
      tick();
      advance = 1'b0;
      chk("zero_pc4", pc4, 32'h0000_0004);
      ack = 1'b1; data = 32'h0020_0093;
      tick();
      ack = 1'b0;
      advance = 1'b1; next_pc = RST_PC;
      tick();
      advance = 1'b0; ack = 1'b1; data = 32'h0030_0093;
      tick();
      ack = 1'b0;
      chk("r5_valid", {31'b0, valid}, 32'd1);
      chk("r5_instr", instr, 32'h0030_0093);
`ifdef RETIRE_COUNT_EN
      chk("retire5", retire_count, 32'd5);
`endif

      // misaligned advance traps, pc holds
      advance = 1'b1; next_pc = 32'h0040_0022;
      tick();
      advance = 1'b0;
      chk("trap_mis",   {31'b0, mis}, 32'd1);
      chk("trap_pc",    pc, RST_PC);
      chk("trap_valid", {31'b0, valid}, 32'd0);
      chk("trap_req",   {31'b0, req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         advance = 1'b1; next_pc = 32'h0040_0040; ack = 1'b1; data = 32'hFFFF_FFFF;
         tick();
         chk("trap_hold_req",   {31'b0, req}, 32'd0);
         chk("trap_hold_pc",    pc, RST_PC);
         chk("trap_hold_mis",   {31'b0, mis}, 32'd1);
         chk("trap_hold_instr", instr, 32'h0030_0093);
      end
      advance = 1'b0; ack = 1'b0;
`ifdef RETIRE_COUNT_EN
      chk("retire6", retire_count, 32'd6);
`endif

      // reset clears the trap; enter WAIT, then reset mid-handshake
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("w_req", {31'b0, req}, 32'd1);
      chk("w_mis", {31'b0, mis}, 32'd0);
      chk("w_pc",  pc, RST_PC);
      reset = 1'b0;
      #1;
      chk("wr_req",   {31'b0, req}, 32'd0);
      chk("wr_valid", {31'b0, valid}, 32'd0);
      chk("wr_instr", instr, NOP);
      ack = 1'b1; data = 32'hCAFE_BABE;
      tick();
      tick();
      chk("wr_ack_instr", instr, NOP);
      chk("wr_ack_req",   {31'b0, req}, 32'd0);
      ack = 1'b0; reset = 1'b1;
      #1;
      chk("rf_req",  {31'b0, req}, 32'd1);
      chk("rf_addr", addr, RST_PC);
      tick();
      ack = 1'b1; data = 32'h0040_0093;
      tick();
      ack = 1'b0;
      chk("rf_valid", {31'b0, valid}, 32'd1);
      chk("rf_instr", instr, 32'h0040_0093);
`ifdef RETIRE_COUNT_EN
      chk("rf_retire", retire_count, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter and fetches instructions for the single-cycle RISC-V core from instruction memory over a req/ack handshake.
- Consumes the next-PC value from the 4:1 next-PC select multiplexer: PC+4, branch target, jal target or jalr target.
- Produces pc_plus_4_o, which feeds that multiplexer's data0 input.
- Presents each fetched instruction to decode and holds it until the core signals retirement.

Parameters:
- NBITS, 32, datapath and address width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset (text segment base).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- next_pc_i  input  NBITS  next PC from the 4:1 next-PC select multiplexer output.
- advance_i  input  1  core retires the current instruction; load next_pc_i.
- fetch_ack_i  input  1  instruction memory returns data this cycle.
- fetch_data_i  input  NBITS  instruction word; valid when fetch_ack_i=1.
- fetch_req_o  output  1  fetch request to instruction memory.
- fetch_addr_o  output  NBITS  fetch address; always equals pc_o.
- pc_o  output  NBITS  current PC.
- pc_plus_4_o  output  NBITS  pc_o+4, modulo 2^NBITS.
- instr_o  output  NBITS  held instruction word.
- instr_valid_o  output  1  instr_o is valid for the current pc_o.
- misaligned_o  output  1  sticky flag: a next PC had bits[1:0]!=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_o=RESET_PC, instr_o=32'h0000_0013 (nop), instr_valid_o=0, fetch_req_o=0, misaligned_o=0.
  - State goes to FETCH.
  - Reset asserted mid-handshake abandons the request; any ack arriving during reset is ignored.
- States:
  - FETCH: fetch_req_o=1. If fetch_ack_i=1 in the same cycle, capture fetch_data_i into instr_o and go to VALID. Otherwise go to WAIT.
  - WAIT: fetch_req_o=1 and fetch_addr_o stable. On fetch_ack_i=1, capture the data and go to VALID.
  - VALID: instr_valid_o=1, fetch_req_o=0, instr_o held.
    - On advance_i=1 with next_pc_i[1:0]==0: pc_o<=next_pc_i, instr_valid_o<=0, go to FETCH.
    - On advance_i=1 with next_pc_i[1:0]!=0: misaligned_o<=1, pc_o unchanged, go to TRAP.
  - TRAP: fetch_req_o=0, instr_valid_o=0. Held until reset.
- Latency:
  - Minimum 2 cycles from PC load to instr_valid_o (FETCH with same-cycle ack, then VALID).
  - Each cycle of ack delay adds 1 cycle.
- advance_i is ignored in FETCH, WAIT and TRAP.
- fetch_ack_i is ignored in VALID and TRAP; stray acks must not corrupt instr_o.
- pc_plus_4_o is combinational from pc_o. Wrap: pc_o=32'hFFFF_FFFC gives pc_plus_4_o=0.
- next_pc_i equal to pc_o (self-loop) is legal and refetches the same address.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count_o [NBITS-1:0], reset to 0.
  - Increments by 1 on each accepted advance in VALID, including the advance that enters TRAP.
  - Wraps at 2^NBITS.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_fetch_pkg:
  - state enum FETCH/WAIT/VALID/TRAP (2-bit encoding).
  - NOP_INSTR=32'h0000_0013.
  - PC_INCREMENT=4.
- One natural sub-module: pc_register. Holds an NBITS register with asynchronous active-low reset to RESET_PC and a load enable. It is reused for any future pipeline PC copies.

Test Plan:
- Reset release, immediate ack with data 32'h0050_0093 -> pc_o=32'h0040_0000, pc_plus_4_o=32'h0040_0004, instr_valid_o=1 two cycles after release, instr_o=32'h0050_0093.
- Ack delayed 3 cycles -> fetch_req_o held high 4 cycles, fetch_addr_o stable, instr_valid_o rises the cycle after the ack.
- In VALID, advance_i=1 with next_pc_i=32'h0040_0020 -> pc_o=32'h0040_0020 next cycle, instr_valid_o=0, new fetch issued to 0x0040_0020.
- advance_i=1 with next_pc_i=32'h0040_0022 -> misaligned_o=1, state TRAP, no further fetch_req_o, pc_o unchanged; only reset clears it.
- reset asserted during WAIT, then ack pulsed while in reset -> outputs at reset values; after release a fresh fetch to RESET_PC.
- With RETIRE_COUNT_EN: 5 advances -> retire_count_o=5. Stray ack in VALID -> instr_o unchanged.
